// File: rtl/gmii_rx_fcs_check.sv
// ============================================================================
// gmii_rx_fcs_check : GMII receive preamble/SFD strip, FCS strip and CRC-32 check
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module gmii_rx_fcs_check #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        e_rxc,
  input  logic        reset,
  input  logic [7:0]  e_rxd,
  input  logic        e_rxdv,
  input  logic        e_rxer,
  output logic [7:0]  data_o,
  output logic        data_o_valid,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_good,
  output logic [15:0] frame_len,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt,
  output logic [1:0]  rx_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam logic [31:0] C_POLY    = 32'hEDB88320;
  localparam logic [31:0] C_RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0] C_MIN_LEN = MIN_LEN;
  localparam logic [31:0] C_MAX_LEN = MAX_LEN;

  state_t      r_state;
  logic [31:0] r_crc;
  logic [15:0] r_byte_cnt;
  logic [31:0] r_dly;
  logic        r_err;

  logic [31:0] w_crc_next;
  logic [15:0] w_cnt_inc;
  logic [15:0] w_len;
  logic        w_len_ok;
  logic        w_good;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ C_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Verdict is formed from state as it stood before the e_rxdv=0 sample,
  // i.e. after the last FCS byte has been folded into the CRC.
  always_comb begin
    w_crc_next = crc32_byte(r_crc, e_rxd);
    w_cnt_inc  = (r_byte_cnt == 16'hFFFF) ? r_byte_cnt : r_byte_cnt + 16'd1;
    w_len      = (r_byte_cnt < 16'd4) ? 16'd0 : r_byte_cnt - 16'd4;
    w_len_ok   = ({16'd0, r_byte_cnt} >= C_MIN_LEN) && ({16'd0, r_byte_cnt} <= C_MAX_LEN);
    w_good     = (r_crc == C_RESIDUE) && !r_err && w_len_ok;
  end

  assign rx_state = r_state;

  always_ff @(posedge e_rxc or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_crc        <= 32'hFFFF_FFFF;
      r_byte_cnt   <= 16'd0;
      r_dly        <= 32'd0;
      r_err        <= 1'b0;
      data_o       <= 8'd0;
      data_o_valid <= 1'b0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
      frame_good   <= 1'b0;
      frame_len    <= 16'd0;
      good_cnt     <= 16'd0;
      bad_cnt      <= 16'd0;
    end else begin
      data_o_valid <= 1'b0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
      frame_good   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (e_rxdv) r_state <= (e_rxd == 8'h55) ? PRE : DROP;
        end
        PRE: begin
          if (!e_rxdv) begin
            r_state <= IDLE;
          end else if (e_rxd == 8'hD5) begin
            r_state    <= DATA;
            r_crc      <= 32'hFFFF_FFFF;
            r_byte_cnt <= 16'd0;
            r_dly      <= 32'd0;
            r_err      <= 1'b0;
          end else if (e_rxd != 8'h55) begin
            r_state <= DROP;
          end
        end
        DATA: begin
          if (e_rxdv) begin
            r_crc      <= w_crc_next;
            r_dly      <= {r_dly[23:0], e_rxd};
            r_byte_cnt <= w_cnt_inc;
            if (e_rxer) r_err <= 1'b1;
            // Oldest byte in the delay line leaves once four are buffered;
            // the last four (FCS) are still buffered when the frame ends.
            if (r_byte_cnt >= 16'd4) begin
              data_o       <= r_dly[31:24];
              data_o_valid <= 1'b1;
              frame_start  <= (r_byte_cnt == 16'd4);
            end
          end else begin
            r_state    <= IDLE;
            frame_done <= 1'b1;
            frame_good <= w_good;
            frame_len  <= w_len;
            if (w_good) begin
              if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
            end else begin
              if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
            end
          end
        end
        DROP: begin
          if (!e_rxdv) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
